// File: rtl/traffic_sensor_interface.sv
// traffic_sensor_interface: conditions raw loop detectors into controller demand and tracks the lamp sequence
//   clk, reset            : clock, synchronous active-high reset
//   det_a, det_b          : raw asynchronous vehicle-loop detectors
//   Ra..Gb                : lamp drives sampled from the light controller
//   Sa, Sb                : registered demand (debounced level or latched request)
//   phase, phase_valid    : tracked phase (0 A green, 1 A yellow, 2 B green, 3 B yellow) and its validity
//   fault, fault_code     : sticky first lamp-sequence fault and its cause
//   cycle_count           : completed light cycles, saturating
module traffic_sensor_interface #(
    parameter int DB_CYCLES = 4,
    parameter int YMIN      = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       det_a,
    input  logic       det_b,
    input  logic       Ra,
    input  logic       Ya,
    input  logic       Ga,
    input  logic       Rb,
    input  logic       Yb,
    input  logic       Gb,
    output logic       Sa,
    output logic       Sb,
    output logic [1:0] phase,
    output logic       phase_valid,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic [7:0] cycle_count
);
    typedef enum logic [2:0] {P0 = 3'd0, P1 = 3'd1, P2 = 3'd2, P3 = 3'd3, UNK = 3'd4} state_t;

    localparam logic [3:0] DB_LAST = 4'(DB_CYCLES - 1);

    logic [1:0] w_det, w_grn, w_rise;
    logic [1:0] r_sync1, r_sync2, r_db, r_req, r_s;
    logic [3:0] r_cnt [2];

    assign w_det = {det_b, det_a};
    assign w_grn = {Gb, Ga};

    // A debounced rising edge is the cycle the level flips from 0 to 1.
    always_comb begin
        for (int k = 0; k < 2; k++)
            w_rise[k] = r_sync2[k] & ~r_db[k] & (r_cnt[k] == DB_LAST);
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                r_sync1[k] <= 1'b0;
                r_sync2[k] <= 1'b0;
                r_db[k]    <= 1'b0;
                r_cnt[k]   <= 4'd0;
                r_req[k]   <= 1'b0;
                r_s[k]     <= 1'b0;
            end else begin
                r_sync1[k] <= w_det[k];
                r_sync2[k] <= r_sync1[k];
                if (r_sync2[k] == r_db[k]) begin
                    r_cnt[k] <= 4'd0;
                end else if (r_cnt[k] == DB_LAST) begin
                    r_db[k]  <= r_sync2[k];
                    r_cnt[k] <= 4'd0;
                end else begin
                    r_cnt[k] <= r_cnt[k] + 4'd1;
                end
                // Green on the street clears its request and overrides a same-cycle set.
                r_req[k] <= w_grn[k] ? 1'b0 : (w_rise[k] | r_req[k]);
                r_s[k]   <= r_db[k] | r_req[k];
            end
        end
    end

    assign Sa = r_s[0];
    assign Sb = r_s[1];

    state_t     r_state, w_next;
    logic [3:0] r_ycnt;
    logic [2:0] w_code;
    logic [1:0] w_lph;
    logic       w_legal;
    logic       r_fault;
    logic [2:0] r_fault_code;
    logic [7:0] r_cycle_count;

    always_comb begin
        w_legal = 1'b1;
        w_lph   = 2'd0;
        case ({Ga, Ya, Ra, Gb, Yb, Rb})
            6'b100001: w_lph = 2'd0;
            6'b010001: w_lph = 2'd1;
            6'b001100: w_lph = 2'd2;
            6'b001010: w_lph = 2'd3;
            default:   w_legal = 1'b0;
        endcase
        w_next = r_state;
        w_code = 3'd0;
        if (r_state == UNK) begin
            if (w_legal) w_next = state_t'({1'b0, w_lph});
        end else if (!w_legal) begin
            w_code = (Ga & Gb) ? 3'd4 : 3'd1;
        end else if (w_lph == r_state[1:0] + 2'd1) begin
            w_next = state_t'({1'b0, w_lph});
            // Odd phases are the yellows; a short one is flagged but still left.
            if (r_state[0] && {28'd0, r_ycnt} < YMIN) w_code = 3'd3;
        end else if (w_lph != r_state[1:0]) begin
            w_code = 3'd2;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= UNK;
            r_ycnt        <= 4'd0;
            r_fault       <= 1'b0;
            r_fault_code  <= 3'd0;
            r_cycle_count <= 8'd0;
        end else begin
            r_state <= w_next;
            r_ycnt  <= (w_next != r_state) ? 4'd1 : ((r_ycnt == 4'd15) ? r_ycnt : r_ycnt + 4'd1);
            if (!r_fault && w_code != 3'd0) begin
                r_fault      <= 1'b1;
                r_fault_code <= w_code;
            end
            if (r_state == P3 && w_next == P0 && r_cycle_count != 8'hFF)
                r_cycle_count <= r_cycle_count + 8'd1;
        end
    end

    assign phase       = r_state[1:0];
    assign phase_valid = (r_state != UNK);
    assign fault       = r_fault;
    assign fault_code  = r_fault_code;
    assign cycle_count = r_cycle_count;
endmodule

// File: tb/tb_traffic_sensor_interface.sv
// tb_traffic_sensor_interface: directed vector bench for traffic_sensor_interface
module tb_traffic_sensor_interface;
    localparam logic [5:0] L0  = 6'b100001;
    localparam logic [5:0] L1  = 6'b010001;
    localparam logic [5:0] L2  = 6'b001100;
    localparam logic [5:0] L3  = 6'b001010;
    localparam logic [5:0] LX  = 6'b000000;
    localparam logic [5:0] LGG = 6'b100100;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       det_a = 1'b0, det_b = 1'b0;
    logic       Ra = 1'b0, Ya = 1'b0, Ga = 1'b0, Rb = 1'b0, Yb = 1'b0, Gb = 1'b0;
    logic       Sa, Sb, pv, flt;
    logic [1:0] ph;
    logic [2:0] code;
    logic [7:0] cc;
    logic       y_Sa, y_Sb, y_pv, y_flt;
    logic [1:0] y_ph;
    logic [2:0] y_code;
    logic [7:0] y_cc;

    int n_chk = 0;
    int n_fail = 0;

    traffic_sensor_interface u_dut (
        .clk(clk), .reset(reset), .det_a(det_a), .det_b(det_b),
        .Ra(Ra), .Ya(Ya), .Ga(Ga), .Rb(Rb), .Yb(Yb), .Gb(Gb),
        .Sa(Sa), .Sb(Sb), .phase(ph), .phase_valid(pv),
        .fault(flt), .fault_code(code), .cycle_count(cc)
    );

    traffic_sensor_interface #(.DB_CYCLES(4), .YMIN(2)) u_y2 (
        .clk(clk), .reset(reset), .det_a(det_a), .det_b(det_b),
        .Ra(Ra), .Ya(Ya), .Ga(Ga), .Rb(Rb), .Yb(Yb), .Gb(Gb),
        .Sa(y_Sa), .Sb(y_Sb), .phase(y_ph), .phase_valid(y_pv),
        .fault(y_flt), .fault_code(y_code), .cycle_count(y_cc)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       rst;
        logic [5:0] lamps;
        logic [1:0] ph;
        logic       v;
        logic       f;
        logic [2:0] code;
        logic [7:0] cc;
    } vec_t;

    vec_t tbl [26];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_l(input logic [5:0] l);
        {Ga, Ya, Ra, Gb, Yb, Rb} = l;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset(input logic [5:0] l);
        set_l(l);
        det_a = 1'b0;
        det_b = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        tbl[0]  = '{1'b1, L0,  2'd0, 1'b0, 1'b0, 3'd0, 8'd0};
        tbl[1]  = '{1'b0, LX,  2'd0, 1'b0, 1'b0, 3'd0, 8'd0};
        tbl[2]  = '{1'b0, L0,  2'd0, 1'b1, 1'b0, 3'd0, 8'd0};
        tbl[3]  = '{1'b0, L0,  2'd0, 1'b1, 1'b0, 3'd0, 8'd0};
        tbl[4]  = '{1'b0, L0,  2'd0, 1'b1, 1'b0, 3'd0, 8'd0};
        tbl[5]  = '{1'b0, L1,  2'd1, 1'b1, 1'b0, 3'd0, 8'd0};
        tbl[6]  = '{1'b0, L2,  2'd2, 1'b1, 1'b0, 3'd0, 8'd0};
        tbl[7]  = '{1'b0, L2,  2'd2, 1'b1, 1'b0, 3'd0, 8'd0};
        tbl[8]  = '{1'b0, L3,  2'd3, 1'b1, 1'b0, 3'd0, 8'd0};
        tbl[9]  = '{1'b0, L0,  2'd0, 1'b1, 1'b0, 3'd0, 8'd1};
        tbl[10] = '{1'b0, L2,  2'd0, 1'b1, 1'b1, 3'd2, 8'd1};
        tbl[11] = '{1'b0, L1,  2'd1, 1'b1, 1'b1, 3'd2, 8'd1};
        tbl[12] = '{1'b0, LX,  2'd1, 1'b1, 1'b1, 3'd2, 8'd1};
        tbl[13] = '{1'b1, L0,  2'd0, 1'b0, 1'b0, 3'd0, 8'd0};
        tbl[14] = '{1'b0, L0,  2'd0, 1'b1, 1'b0, 3'd0, 8'd0};
        tbl[15] = '{1'b0, LX,  2'd0, 1'b1, 1'b1, 3'd1, 8'd0};
        tbl[16] = '{1'b1, L0,  2'd0, 1'b0, 1'b0, 3'd0, 8'd0};
        tbl[17] = '{1'b0, L0,  2'd0, 1'b1, 1'b0, 3'd0, 8'd0};
        tbl[18] = '{1'b0, L1,  2'd1, 1'b1, 1'b0, 3'd0, 8'd0};
        tbl[19] = '{1'b0, L2,  2'd2, 1'b1, 1'b0, 3'd0, 8'd0};
        tbl[20] = '{1'b0, LGG, 2'd2, 1'b1, 1'b1, 3'd4, 8'd0};
        tbl[21] = '{1'b0, L0,  2'd2, 1'b1, 1'b1, 3'd4, 8'd0};
        tbl[22] = '{1'b1, L3,  2'd0, 1'b0, 1'b0, 3'd0, 8'd0};
        tbl[23] = '{1'b0, L3,  2'd3, 1'b1, 1'b0, 3'd0, 8'd0};
        tbl[24] = '{1'b0, L1,  2'd3, 1'b1, 1'b1, 3'd2, 8'd0};
        tbl[25] = '{1'b1, L0,  2'd0, 1'b0, 1'b0, 3'd0, 8'd0};

        for (int i = 0; i < 26; i++) begin
            reset = tbl[i].rst;
            set_l(tbl[i].lamps);
            step();
            chk($sformatf("vec%0d phase", i), ph, tbl[i].ph);
            chk($sformatf("vec%0d valid", i), pv, tbl[i].v);
            chk($sformatf("vec%0d fault", i), flt, tbl[i].f);
            chk($sformatf("vec%0d code", i), code, tbl[i].code);
            chk($sformatf("vec%0d cycles", i), cc, tbl[i].cc);
        end
        chk("reset Sa", Sa, 1'b0);
        chk("reset Sb", Sb, 1'b0);
        reset = 1'b0;

        // Short yellow with YMIN=2: flagged but transition taken
        do_reset(L0);
        step();
        set_l(L1); step();
        set_l(L2); step();
        chk("short yellow phase", y_ph, 2'd2);
        chk("short yellow code", y_code, 3'd3);
        chk("short yellow ymin1 ok", code, 3'd0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("y2 all reset", {y_Sa, y_Sb, y_ph, y_pv, y_flt, y_code, y_cc}, 17'd0);

        // Yellow of exactly YMIN cycles, then a long one past counter saturation
        set_l(L0); step();
        set_l(L1); step(); step();
        set_l(L2); step();
        chk("yellow ymin ok", y_flt, 1'b0);
        chk("yellow ymin phase", y_ph, 2'd2);
        set_l(L3);
        for (int i = 0; i < 20; i++) step();
        set_l(L0); step();
        chk("long yellow ok", y_flt, 1'b0);
        chk("long yellow cycles", y_cc, 8'd1);

        // cycle_count saturation
        do_reset(L0);
        step();
        for (int i = 0; i < 256; i++) begin
            set_l(L1); step();
            set_l(L2); step();
            set_l(L3); step();
            set_l(L0); step();
            if (i == 0 || i >= 253)
                chk($sformatf("cycles after %0d", i + 1), cc, (i >= 254) ? 8'd255 : 8'(i + 1));
        end
        chk("no fault long run", flt, 1'b0);

        // det_b debounce and latch with A green
        do_reset(L0);
        det_b = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            step();
            if (c == 6) det_b = 1'b0;
            if (c >= 5) chk($sformatf("Sb edge %0d", c), Sb, c == 7);
        end
        for (int c = 0; c < 12; c++) step();
        chk("Sb held by request", Sb, 1'b1);
        chk("Sa idle", Sa, 1'b0);
        set_l(L2); step();
        chk("Sb Gb first edge", Sb, 1'b1);
        step();
        chk("Sb cleared by Gb", Sb, 1'b0);

        // reset mid-debounce discards the partial count
        do_reset(L0);
        det_b = 1'b1;
        for (int c = 0; c < 5; c++) step();
        reset = 1'b1; step(); reset = 1'b0;
        chk("mid reset Sb", Sb, 1'b0);
        for (int c = 1; c <= 7; c++) begin
            step();
            if (c >= 6) chk($sformatf("post reset Sb edge %0d", c), Sb, c == 7);
        end
        det_b = 1'b0;

        // det_a chatter with A red never produces demand
        do_reset(L2);
        for (int c = 0; c < 20; c++) begin
            det_a = ~det_a;
            step();
            chk($sformatf("chatter Sa %0d", c), Sa, 1'b0);
        end
        do_reset(L2);
        det_a = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            step();
            if (c == 6) det_a = 1'b0;
            if (c >= 6) chk($sformatf("Sa edge %0d", c), Sa, c == 7);
        end
        for (int c = 0; c < 12; c++) step();
        chk("Sa held by request", Sa, 1'b1);
        set_l(L0); step(); step();
        chk("Sa cleared by Ga", Sa, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
